bit_serial_eq_ctrl: RTL

Sequential controller that time-shares a single 1-bit XNOR equality cell to compare two WIDTH-bit words. Bits are compared LSB-first, one bit per clock. The controller accumulates the bit results and reports word equality plus the index of the first mismatching bit. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side.

---
 rtl/bit_serial_eq_ctrl_pkg.sv | 7 +
 rtl/bit_serial_eq_ctrl_xnor_bit_cell.sv | 8 +
 rtl/bit_serial_eq_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/bit_serial_eq_ctrl_pkg.sv
// bit_serial_eq_ctrl_pkg: state encodings and default width for the bit-serial equality controller
package bit_serial_eq_ctrl_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
endpackage

// File: rtl/bit_serial_eq_ctrl_xnor_bit_cell.sv
// xnor_bit_cell: the single shared 1-bit equality cell
module xnor_bit_cell (
  output logic s,
  input  logic a,
  input  logic b
);
  assign s = ~(a ^ b);
endmodule

// File: rtl/bit_serial_eq_ctrl.sv
// bit_serial_eq_ctrl: compares two words LSB-first through one XNOR cell, reporting equality and first mismatch index
module bit_serial_eq_ctrl
  import bit_serial_eq_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int IDXW       = $clog2(WIDTH),
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic [IDXW-1:0]  mismatch_idx,
  output logic             busy
);
  localparam logic [IDXW-1:0] CNT_LAST = IDXW'(WIDTH - 1);
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [IDXW-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic acc_q, acc_d, seen_q, seen_d, out_valid_q, out_valid_d, eq_q, eq_d;
  logic x, last;
  xnor_bit_cell u_cell (.s(x), .a(sa_q[0]), .b(sb_q[0]));
  assign last = (cnt_q == CNT_LAST) || (EARLY_EXIT && !x);
  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    seen_d      = seen_q;
    out_valid_d = out_valid_q;
    eq_d        = eq_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SHIFT;
        sa_d    = a;
        sb_d    = b;
        cnt_d   = '0;
        idx_d   = '0;
        acc_d   = 1'b1;
        seen_d  = 1'b0;
        eq_d    = 1'b0;
      end
      SHIFT: begin
        acc_d  = acc_q & x;
        idx_d  = (!x && !seen_q) ? cnt_q : idx_q;
        seen_d = seen_q | !x;
        sa_d   = sa_q >> 1;
        sb_d   = sb_q >> 1;
        // hold cnt on the final bit so it never wraps inside a job
        cnt_d  = last ? cnt_q : cnt_q + IDXW'(1);
        if (last) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          eq_d        = acc_q & x;
        end
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      acc_q       <= 1'b1;
      seen_q      <= 1'b0;
      out_valid_q <= 1'b0;
      eq_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      seen_q      <= seen_d;
      out_valid_q <= out_valid_d;
      eq_q        <= eq_d;
    end
  end
  assign in_ready     = state_q == IDLE;
  assign busy         = state_q == SHIFT;
  assign out_valid    = out_valid_q;
  assign eq           = eq_q;
  assign mismatch_idx = eq_q ? '0 : idx_q;
endmodule
